// File: rtl/conv_requant_collector_if.sv
// Stream bundle for conv_requant_collector: raw MAC samples in, requantized pixels out.
// The slave modport is the collector's view; master is the convolver/writer side.
interface conv_requant_collector_if #(
  parameter int MAC_W = 36,
  parameter int OUT_W = 16
);
  logic             mac_valid;
  logic [MAC_W-1:0] output_mac;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  mac_valid, output_mac, out_ready,
    output out_data, out_valid
  );

  modport master (
    output mac_valid, output_mac, out_ready,
    input  out_data, out_valid
  );
endinterface

// File: rtl/conv_requant_collector.sv
// Drops the two wrap-around columns per row, then rounds/shifts/saturates/ReLUs each window into a pixel.
// Input to FIFO write is 2 cycles; nothing stalls upstream, so a write into a full FIFO is dropped and flagged.
module conv_requant_collector #(
  parameter int MAC_W      = 36,
  parameter int OUT_W      = 16,
  parameter int ROW_W      = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ROW_W-1:0] row_length,
  input  logic [ROW_W-1:0] num_rows,
  input  logic [5:0]       shift,
  input  logic             relu_en,
  conv_requant_collector_if.slave bus,
  output logic             busy,
  output logic             frame_done,
  output logic             overflow
);
  localparam int T_W = MAC_W + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [5:0] SHIFT_MAX = 6'(MAC_W - 1);
  localparam logic signed [T_W-1:0] SAT_MAX = T_W'((longint'(1) << (OUT_W - 1)) - 1);
  localparam logic signed [T_W-1:0] SAT_MIN = T_W'(-(longint'(1) << (OUT_W - 1)));
  localparam logic [AW:0] FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [ROW_W-1:0]        w_q, w_d, r_q, r_d, col_q, col_d, row_q, row_d;
  logic [5:0]              sh_q, sh_d;
  logic                    relu_q, relu_d;
  logic                    s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic signed [T_W-1:0]   s1_dat_q, s1_dat_d;
  logic [OUT_W-1:0]        s2_dat_q, s2_dat_d;
  logic [OUT_W-1:0]        mem_q [FIFO_DEPTH];
  logic [OUT_W-1:0]        mem_d [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]             cnt_q, cnt_d;
  logic                    done_q, done_d, ovf_q, ovf_d;

  logic                    fifo_rd, fifo_wr, take;
  logic signed [T_W-1:0]   mac_ext, rnd, sum;

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    r_d      = r_q;
    sh_d     = sh_q;
    relu_d   = relu_q;
    col_d    = col_q;
    row_d    = row_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    take     = 1'b0;

    // Read is folded in before the write so a full FIFO can accept on the same edge it is read.
    fifo_rd = (cnt_q != '0) && bus.out_ready;
    fifo_wr = s2_vld_q && ((cnt_q != FIFO_FULL) || fifo_rd);
    if (s2_vld_q && !fifo_wr) ovf_d = 1'b1;
    if (fifo_wr) begin
      mem_d[wr_ptr_q] = s2_dat_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (fifo_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + (AW + 1)'(fifo_wr) - (AW + 1)'(fifo_rd);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (row_length >= ROW_W'(3) && num_rows != '0) begin
            state_d = RUN;
            w_d     = row_length;
            r_d     = num_rows;
            sh_d    = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
            relu_d  = relu_en;
            col_d   = '0;
            row_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.mac_valid) begin
          take = (col_q <= w_q - ROW_W'(3));
          if (col_q == w_q - ROW_W'(1)) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
            if (row_q == r_q - ROW_W'(1)) state_d = DRAIN;
          end else begin
            col_d = col_q + ROW_W'(1);
          end
        end
      end
      DRAIN: begin
        // Finish on the edge that empties the FIFO so frame_done lands right after the last read.
        if (!s1_vld_q && !s2_vld_q && cnt_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mac_ext  = {bus.output_mac[MAC_W-1], bus.output_mac};
    rnd      = (sh_q == 6'd0) ? '0 : (T_W'(1) << (sh_q - 6'd1));
    sum      = mac_ext + rnd;
    s1_vld_d = take;
    s1_dat_d = sum >>> sh_q;

    s2_vld_d = s1_vld_q;
    if (relu_q && s1_dat_q[T_W-1]) s2_dat_d = '0;
    else if (s1_dat_q > SAT_MAX)   s2_dat_d = SAT_MAX[OUT_W-1:0];
    else if (s1_dat_q < SAT_MIN)   s2_dat_d = SAT_MIN[OUT_W-1:0];
    else                           s2_dat_d = s1_dat_q[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      w_q      <= '0;
      r_q      <= '0;
      sh_q     <= '0;
      relu_q   <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
      s2_vld_q <= 1'b0;
      s2_dat_q <= '0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      r_q      <= r_d;
      sh_q     <= sh_d;
      relu_q   <= relu_d;
      col_q    <= col_d;
      row_q    <= row_d;
      s1_vld_q <= s1_vld_d;
      s1_dat_q <= s1_dat_d;
      s2_vld_q <= s2_vld_d;
      s2_dat_q <= s2_dat_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.out_valid = (cnt_q != '0);
  assign bus.out_data  = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign busy          = (state_q != IDLE);
  assign frame_done    = done_q;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_conv_requant_collector.sv
// Directed bench for conv_requant_collector: a frame-level reference model predicts every output cycle,
// and literal expectations pin the model on the key scenarios.
module tb_conv_requant_collector;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] row_length = '0;
  logic [9:0] num_rows = '0;
  logic [5:0] shift = '0;
  logic       relu_en = 1'b0;
  logic       busy, frame_done, overflow;

  conv_requant_collector_if #(.MAC_W(36), .OUT_W(16)) bus ();

  conv_requant_collector #(.MAC_W(36), .OUT_W(16), .ROW_W(10), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst_n), .start(start), .row_length(row_length), .num_rows(num_rows),
    .shift(shift), .relu_en(relu_en), .bus(bus), .busy(busy), .frame_done(frame_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: spec arithmetic on plain integers.
  function automatic int requant(input logic [35:0] mac, input int sh, input bit relu);
    longint t;
    t = longint'($signed(mac));
    if (sh > 35) sh = 35;
    if (sh > 0) t = t + (longint'(1) << (sh - 1));
    t = t >>> sh;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    if (relu && t < 0) t = 0;
    return int'(t);
  endfunction

  typedef struct { int t; int v; } pend_t;
  pend_t pend[$];
  int    mfifo[$];
  int    got[$];
  int    cyc = 0;
  bit    m_active = 0, m_drain = 0, m_ovf = 0, m_done = 0, m_dn = 0;
  int    m_w = 0, m_r = 0, m_sh = 0, m_n = 0, m_fs = 0;
  bit    m_relu = 0;
  pend_t p;

  // Model: a kept sample lands in the FIFO two edges after it is taken; frames count samples, not columns.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      mfifo.delete();
      m_active = 0; m_drain = 0; m_ovf = 0; m_done = 0; m_n = 0;
    end else begin
      m_dn = 0;
      if (bus.out_valid && bus.out_ready) got.push_back(int'($signed(bus.out_data)));
      if (mfifo.size() > 0 && bus.out_ready) void'(mfifo.pop_front());
      while (pend.size() > 0 && pend[0].t == cyc) begin
        if (mfifo.size() < DEPTH) mfifo.push_back(pend[0].v);
        else m_ovf = 1;
        void'(pend.pop_front());
      end
      if (!m_active && !m_drain) begin
        if (start) begin
          if (row_length >= 3 && num_rows >= 1) begin
            m_w = int'(row_length); m_r = int'(num_rows); m_sh = int'(shift); m_relu = relu_en;
            m_n = 0; m_ovf = 0; m_active = 1;
          end else m_dn = 1;
        end
      end else if (m_active && bus.mac_valid) begin
        if (m_n == 0) m_fs = cyc;
        if ((m_n % m_w) <= m_w - 3) begin
          p.t = cyc + 2;
          p.v = requant(bus.output_mac, m_sh, m_relu);
          pend.push_back(p);
        end
        m_n++;
        if (m_n == m_w * m_r) begin m_active = 0; m_drain = 1; end
      end
      if (m_drain && pend.size() == 0 && mfifo.size() == 0) begin m_drain = 0; m_dn = 1; end
      m_done = m_dn;
      cyc++;
    end
  end

  int done_cnt = 0;
  int lat = -1;
  bit armed = 1;

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_out_valid", longint'(bus.out_valid), longint'(mfifo.size() > 0));
      if (mfifo.size() > 0) chk("cmp_out_data", longint'($signed(bus.out_data)), longint'(mfifo[0]));
      chk("cmp_busy", longint'(busy), longint'(m_active || m_drain));
      chk("cmp_frame_done", longint'(frame_done), longint'(m_done));
      chk("cmp_overflow", longint'(overflow), longint'(m_ovf));
      if (frame_done) done_cnt++;
      if (!(m_active || m_drain)) armed = 1;
      else if (armed && bus.out_valid) begin lat = cyc - m_fs; armed = 0; end
    end
  end

  task automatic do_start(input int w, input int r, input int sh, input bit relu);
    row_length = 10'(w); num_rows = 10'(r); shift = 6'(sh); relu_en = relu;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input longint v);
    bus.mac_valid  = 1'b1;
    bus.output_mac = v[35:0];
    @(negedge clk);
    bus.mac_valid  = 1'b0;
  endtask

  task automatic wait_done(input int base, input int max);
    for (int i = 0; i < max && done_cnt == base; i++) @(negedge clk);
    @(negedge clk);
    chk("frame_done_seen", longint'(done_cnt - base), 1);
  endtask

  task automatic check_pixels(input string nm, input int base, input int exp[$]);
    chk({nm, "_count"}, longint'(got.size() - base), longint'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (base + i < got.size()) chk(nm, longint'(got[base + i]), longint'(exp[i]));
  endtask

  int exp_q[$];
  int b, d;

  initial begin
    bus.mac_valid = 1'b0; bus.output_mac = '0; bus.out_ready = 1'b1;
    #12;
    chk("rst_out_data", longint'(bus.out_data), 0);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_frame_done", longint'(frame_done), 0);
    chk("rst_overflow", longint'(overflow), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Basic frame: W=6, R=2.
    b = got.size(); d = done_cnt;
    do_start(6, 2, 0, 0);
    for (int i = 0; i < 12; i++) send(i);
    wait_done(d, 60);
    repeat (3) @(negedge clk);
    exp_q = '{0, 1, 2, 3, 6, 7, 8, 9};
    check_pixels("basic", b, exp_q);
    chk("basic_latency", longint'(lat), 3);
    chk("basic_done_once", longint'(done_cnt - d), 1);

    // Rounding and saturation, shift=4.
    b = got.size(); d = done_cnt;
    do_start(8, 1, 4, 0);
    send(24); send(23); send(-24); send(-25); send(longint'(1) << 30); send(-(longint'(1) << 30));
    send(0); send(0);
    wait_done(d, 60);
    exp_q = '{2, 1, -1, -2, 32767, -32768};
    check_pixels("round", b, exp_q);

    // ReLU, shift=0.
    b = got.size(); d = done_cnt;
    do_start(5, 1, 0, 1);
    send(-5); send(7); send(-32769); send(0); send(0);
    wait_done(d, 60);
    exp_q = '{0, 7, 0};
    check_pixels("relu", b, exp_q);

    // Shift request above 35 is clamped to 35.
    b = got.size(); d = done_cnt;
    do_start(3, 1, 40, 0);
    send(longint'(36'h7_FFFF_FFFF)); send(0); send(0);
    wait_done(d, 60);
    exp_q = '{1};
    check_pixels("clamp", b, exp_q);

    // Overflow: consumer stalled for a whole 18-pixel frame.
    b = got.size(); d = done_cnt;
    bus.out_ready = 1'b0;
    do_start(20, 1, 0, 0);
    for (int i = 0; i < 20; i++) send(i);
    repeat (4) @(negedge clk);
    chk("ovf_flag", longint'(overflow), 1);
    chk("ovf_held", longint'(bus.out_valid), 1);
    chk("ovf_busy", longint'(busy), 1);
    bus.out_ready = 1'b1;
    wait_done(d, 60);
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_pixels("ovf_drain", b, exp_q);

    // Degenerate row length: immediate frame_done, no pixels.
    b = got.size(); d = done_cnt;
    do_start(2, 5, 0, 0);
    repeat (3) @(negedge clk);
    chk("w2_done", longint'(done_cnt - d), 1);
    chk("w2_busy", longint'(busy), 0);
    chk("w2_pixels", longint'(got.size() - b), 0);

    // Start pulsed mid-frame is ignored.
    b = got.size(); d = done_cnt;
    do_start(6, 2, 0, 0);
    for (int i = 0; i < 5; i++) send(i);
    start = 1'b1; row_length = 10'd3;
    send(5);
    start = 1'b0;
    for (int i = 6; i < 12; i++) send(i);
    wait_done(d, 60);
    exp_q = '{0, 1, 2, 3, 6, 7, 8, 9};
    check_pixels("restart_ignored", b, exp_q);

    // Reset mid-frame with 3 pixels buffered.
    d = done_cnt;
    bus.out_ready = 1'b0;
    do_start(10, 1, 0, 0);
    for (int i = 0; i < 5; i++) send(i);
    chk("mid_held", longint'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", longint'(bus.out_valid), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_no_done", longint'(done_cnt - d), 0);
    b = got.size(); d = done_cnt;
    do_start(4, 1, 0, 0);
    for (int i = 10; i < 14; i++) send(i);
    wait_done(d, 60);
    exp_q = '{10, 11};
    check_pixels("after_rst", b, exp_q);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected completion", cyc);
    $fatal(1);
  end
endmodule
